// File: rtl/simple_pic_sched_if.sv
// Wishbone classic slave bus for the interrupt scheduler register file.
interface simple_pic_sched_if;
    logic        cyc_i;
    logic        stb_i;
    logic [1:0]  adr_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (output cyc_i, stb_i, adr_i, we_i, dat_i, input dat_o, ack_o);
    modport slave  (input cyc_i, stb_i, adr_i, we_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/simple_pic_sched.sv
// Edge-triggered interrupt scheduler with fixed/round-robin arbitration and a
// claim/EOI handshake so software services one source at a time.
module simple_pic_sched #(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    simple_pic_sched_if.slave  bus,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               int_o
);

    // Only bits 31:1 exist on the bus, so with 32 sources ID 32 cannot be
    // enabled or cleared through the register file.
    localparam int VIS = (NUM_IRQ < 32) ? NUM_IRQ : 31;

    typedef enum logic [1:0] {IDLE, SIGNAL, ACTIVE} state_t;

    state_t state, state_next;

    logic [NUM_IRQ-1:0] pending, pending_next, enable, irq_q;
    logic [NUM_IRQ-1:0] active_req, rot_req, win_mask;
    logic               rotate;
    logic [5:0]         in_service, last_id, base, winner_id;
    logic               winner_valid;
    logic               bus_req, is_claim_rd, is_eoi_wr, claim_ok, eoi_ok;
    logic               wr_ctrl, wr_pend;
    logic [31:0]        rdata;

    assign active_req  = pending & enable;
    assign bus_req     = bus.cyc_i & bus.stb_i & ~bus.ack_o;
    assign wr_ctrl     = bus_req & bus.we_i & (bus.adr_i == 2'd0);
    assign wr_pend     = bus_req & bus.we_i & (bus.adr_i == 2'd1);
    assign is_claim_rd = bus_req & ~bus.we_i & (bus.adr_i == 2'd2);
    assign is_eoi_wr   = bus_req & bus.we_i & (bus.adr_i == 2'd3) &
                         (bus.dat_i[5:0] == in_service);

    // Rotate the request vector so the search origin lands on bit 0, then
    // take the first set bit and map it back to a source ID.
    always_comb begin : winner_search
        int off;
        off          = 0;
        base         = rotate ? last_id : 6'd0;
        rot_req      = (active_req >> base) | (active_req << (NUM_IRQ - int'(base)));
        winner_valid = 1'b0;
        winner_id    = 6'd0;
        win_mask     = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!winner_valid && rot_req[k]) begin
                off = k + int'(base);
                if (off >= NUM_IRQ) off = off - NUM_IRQ;
                winner_valid = 1'b1;
                winner_id    = 6'(off + 1);
                win_mask     = NUM_IRQ'(1) << off;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.adr_i)
            2'd0: rdata = (32'(enable[VIS-1:0]) << 1) | {31'd0, rotate};
            2'd1: rdata = 32'(pending[VIS-1:0]) << 1;
            2'd2: rdata = (state == SIGNAL && winner_valid) ? {26'd0, winner_id} : 32'd0;
            2'd3: rdata = {26'd0, in_service};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        claim_ok   = 1'b0;
        eoi_ok     = 1'b0;
        case (state)
            IDLE: if (winner_valid) state_next = SIGNAL;
            SIGNAL: begin
                if (!winner_valid) begin
                    state_next = IDLE;
                end else if (is_claim_rd) begin
                    claim_ok   = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (is_eoi_wr) begin
                    eoi_ok     = 1'b1;
                    state_next = winner_valid ? SIGNAL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            int_o <= 1'b0;
        end else begin
            state <= state_next;
            int_o <= (state_next == SIGNAL);
        end
    end

    // A fresh edge is OR-ed in last so it survives a same-cycle clear or claim.
    always_comb begin
        pending_next = pending;
        if (wr_pend)  pending_next = pending_next & ~NUM_IRQ'(bus.dat_i[VIS:1]);
        if (claim_ok) pending_next = pending_next & ~win_mask;
        pending_next = pending_next | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending    <= '0;
            enable     <= '0;
            rotate     <= 1'b0;
            in_service <= 6'd0;
            last_id    <= 6'd0;
            irq_q      <= '0;
            bus.ack_o  <= 1'b0;
            bus.dat_o  <= 32'd0;
        end else begin
            irq_q     <= irq_i;
            pending   <= pending_next;
            bus.ack_o <= bus_req;
            bus.dat_o <= (bus_req && !bus.we_i) ? rdata : 32'd0;
            if (wr_ctrl) begin
                enable <= NUM_IRQ'(bus.dat_i[VIS:1]);
                rotate <= bus.dat_i[0];
            end
            if (claim_ok) begin
                in_service <= winner_id;
                last_id    <= winner_id;
            end else if (eoi_ok) begin
                in_service <= 6'd0;
            end
        end
    end

endmodule

// File: tb/tb_simple_pic_sched.sv
// Bench for simple_pic_sched: a source-level model tracks pending/enable/in-service
// and the expected bus and int_o behaviour, checked every cycle plus directed literals.
module tb_simple_pic_sched;

    localparam int N = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] irq_i;
    logic         int_o;

    simple_pic_sched_if bus ();

    simple_pic_sched #(.NUM_IRQ(N)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .irq_i (irq_i),
        .int_o (int_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Model state: per-ID bits and plain integer IDs.
    bit [N:1]     m_pend, m_en;
    bit           m_rot;
    int           m_last, m_ins;
    logic [N-1:0] m_irqq;
    bit           m_int, m_ack, m_rd;
    logic [31:0]  m_dat;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int model_winner();
        int start;
        start = m_rot ? m_last : 0;
        for (int k = 0; k < N; k++) begin
            int id;
            id = ((start + k) % N) + 1;
            if (m_pend[id] && m_en[id]) return id;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input int a, input int w);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            0: begin
                r[0] = m_rot;
                for (int id = 1; id <= N; id++) r[id] = m_en[id];
            end
            1: for (int id = 1; id <= N; id++) r[id] = m_pend[id];
            2: r = (m_int && w != 0) ? 32'(w) : 32'd0;
            default: r = 32'(m_ins);
        endcase
        return r;
    endfunction

    // Spec-level model: a claim is possible only while the CPU is being
    // signalled; int_o follows "nothing in service and something to serve".
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_pend = '0; m_en = '0; m_rot = 0; m_last = 0; m_ins = 0;
            m_irqq = '0; m_int = 0; m_ack = 0; m_rd = 0; m_dat = 0;
        end else begin
            int w, a;
            bit req, rd, claim;
            logic [31:0] d, rdata;
            bit [N:1] np;
            w     = model_winner();
            a     = int'(bus.adr_i);
            d     = bus.dat_i;
            req   = bus.cyc_i && bus.stb_i && !m_ack;
            rd    = req && !bus.we_i;
            rdata = model_read(a, w);
            claim = rd && a == 2 && m_int && w != 0;
            for (int id = 1; id <= N; id++) begin
                np[id] = m_pend[id];
                if (req && bus.we_i && a == 1 && d[id]) np[id] = 0;
                if (claim && id == w) np[id] = 0;
                if (irq_i[id-1] && !m_irqq[id-1]) np[id] = 1;
            end
            m_pend = np;
            if (req && bus.we_i && a == 0) begin
                m_rot = d[0];
                for (int id = 1; id <= N; id++) m_en[id] = (id < 32) ? d[id] : 1'b0;
            end
            if (claim) begin
                m_ins  = w;
                m_last = w;
            end else if (req && bus.we_i && a == 3 && m_ins != 0 && int'(d[5:0]) == m_ins) begin
                m_ins = 0;
            end
            m_int  = (m_ins == 0) && (w != 0);
            m_ack  = req;
            m_rd   = rd;
            m_dat  = rd ? rdata : 32'd0;
            m_irqq = irq_i;
        end
    end

    always @(negedge clk_i) begin
        if (checking) begin
            check_output("int_o", {31'd0, int_o}, {31'd0, m_int});
            check_output("ack_o", {31'd0, bus.ack_o}, {31'd0, m_ack});
            if (m_ack && m_rd) check_output("dat_o", bus.dat_o, m_dat);
        end
    end

    task automatic bus_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd);
        int n;
        @(negedge clk_i);
        bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = a; bus.we_i = w; bus.dat_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.ack_o && n < 5);
        if (!bus.ack_o) check_output("ack_timeout", {31'd0, bus.ack_o}, 32'd1);
        rd = bus.dat_o;
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.dat_i = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bus_xfer(a, 1'b1, d, rd);
    endtask

    task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus_xfer(a, 1'b0, 32'd0, rd);
        check_output(name, rd, exp);
    endtask

    task automatic pulse_irq(input logic [N-1:0] mask);
        @(negedge clk_i);
        irq_i = irq_i | mask;
        @(negedge clk_i);
        irq_i = irq_i & ~mask;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int claim_order [4] = '{1, 2, 3, 1};
        rst_i = 1; irq_i = '0;
        bus.cyc_i = 0; bus.stb_i = 0; bus.adr_i = 0; bus.we_i = 0; bus.dat_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        checking = 1;
        check_output("rst_int", {31'd0, int_o}, 32'd0);
        check_output("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check_output("rst_dat", bus.dat_o, 32'd0);
        bus_read("rst_ctrl", 2'd0, 32'd0);
        bus_read("rst_pend", 2'd1, 32'd0);
        bus_read("rst_claim", 2'd2, 32'd0);
        bus_read("rst_eoi", 2'd3, 32'd0);

        // Single source: two-cycle int_o latency, claim, pending drained.
        bus_write(2'd0, 32'h6);
        @(negedge clk_i);
        irq_i[1] = 1'b1;
        @(negedge clk_i);
        irq_i[1] = 1'b0;
        check_output("int_latency_1", {31'd0, int_o}, 32'd0);
        @(negedge clk_i);
        check_output("int_latency_2", {31'd0, int_o}, 32'd1);
        bus_read("claim_id2", 2'd2, 32'd2);
        bus_read("pend_after_claim", 2'd1, 32'd0);
        check_output("int_after_claim", {31'd0, int_o}, 32'd0);
        bus_write(2'd3, 32'd2);

        // Fixed priority between IDs 1 and 3.
        bus_write(2'd0, 32'hA);
        pulse_irq(8'b0000_0101);
        wait_cycles(1);
        bus_read("fixed_claim1", 2'd2, 32'd1);
        bus_write(2'd3, 32'd1);
        check_output("int_reassert", {31'd0, int_o}, 32'd1);
        bus_read("fixed_claim3", 2'd2, 32'd3);
        bus_write(2'd3, 32'd3);
        wait_cycles(1);
        check_output("int_idle", {31'd0, int_o}, 32'd0);

        // Round-robin: origin follows the last claimed ID and wraps.
        bus_write(2'd0, 32'hF);
        for (int i = 0; i < 4; i++) begin
            pulse_irq(8'b0000_0111);
            wait_cycles(1);
            bus_read("rr_claim", 2'd2, 32'(claim_order[i]));
            bus_write(2'd3, 32'(claim_order[i]));
        end
        bus_write(2'd1, 32'hE);
        wait_cycles(2);
        check_output("rr_cleared_int", {31'd0, int_o}, 32'd0);
        bus_read("rr_cleared_pend", 2'd1, 32'd0);

        // ACTIVE: no nesting, mismatched EOI ignored.
        bus_write(2'd0, 32'h4);
        pulse_irq(8'b0000_0010);
        wait_cycles(1);
        bus_read("active_claim", 2'd2, 32'd2);
        bus_read("active_claim_again", 2'd2, 32'd0);
        bus_write(2'd3, 32'd5);
        bus_read("eoi_ignored", 2'd3, 32'd2);
        bus_write(2'd3, 32'd2);
        bus_read("eoi_done", 2'd3, 32'd0);
        check_output("eoi_idle_int", {31'd0, int_o}, 32'd0);

        // Masked source keeps pending and is signalled once enabled.
        bus_write(2'd0, 32'h0);
        pulse_irq(8'b0000_1000);
        wait_cycles(3);
        check_output("masked_int", {31'd0, int_o}, 32'd0);
        bus_read("masked_pend", 2'd1, 32'h10);
        bus_write(2'd0, 32'h10);
        wait_cycles(2);
        check_output("unmasked_int", {31'd0, int_o}, 32'd1);
        bus_write(2'd1, 32'h10);
        wait_cycles(2);
        check_output("w1c_int", {31'd0, int_o}, 32'd0);
        bus_read("w1c_pend", 2'd1, 32'd0);

        // Edge set beats write-1-to-clear on the same edge.
        bus_write(2'd0, 32'h0);
        @(negedge clk_i);
        bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = 2'd1; bus.we_i = 1; bus.dat_i = 32'h4;
        irq_i[1] = 1'b1;
        @(negedge clk_i);
        check_output("same_edge_ack", {31'd0, bus.ack_o}, 32'd1);
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.dat_i = 0;
        irq_i[1] = 1'b0;
        bus_read("same_edge_pend", 2'd1, 32'h4);

        // Reset while signalling.
        bus_write(2'd0, 32'h4);
        wait_cycles(2);
        check_output("pre_reset_int", {31'd0, int_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        check_output("post_reset_int", {31'd0, int_o}, 32'd0);
        check_output("post_reset_ack", {31'd0, bus.ack_o}, 32'd0);
        bus_read("post_reset_ctrl", 2'd0, 32'd0);
        bus_read("post_reset_pend", 2'd1, 32'd0);
        bus_read("post_reset_eoi", 2'd3, 32'd0);

        wait_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
